// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Purpose  : Shared types and constants for the framed UART transmitter.     |
// |            Parity-mode and FSM-state encodings, line idle level.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  // Runtime parity selection; 2'b11 is reserved and behaves as "none".
  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_RSVD  = 2'b11
  } parity_e;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Level driven on the serial line whenever no frame is in flight.
  localparam logic IDLE_LEVEL = 1'b1;

  // True when the mode inserts a parity bit into the frame.
  function automatic logic parity_enabled(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Purpose  : Synchronous input FIFO for uart_tx_framed. Only built when      |
// |            UART_TX_FIFO_EN is defined. Pointers and count are              |
// |            log2(DEPTH)+1 bits wide and wrap naturally.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef UART_TX_FIFO_EN
module uart_tx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] wr_data_in,
  output logic             full_out,
  input  logic             pop_in,
  output logic [WIDTH-1:0] rd_data_out,
  output logic             empty_out
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full when the pointers differ only in their wrap bit; a push into a full
  // FIFO is refused even if a pop happens in the same cycle.
  assign full_out    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign empty_out   = (count_q == '0);
  assign do_push     = push_in && !full_out;
  assign do_pop      = pop_in && !empty_out;
  assign rd_data_out = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_in;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/uart_tx_framed.sv
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_framed                                                  |
// | Purpose  : Parametrised UART transmitter: start, DATA_BITS data (LSB       |
// |            first), optional runtime parity, STOP_BITS stop bits.           |
// |            valid/ready input, gapless back-to-back frames.                 |
// | Options  : define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry input FIFO. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 694,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DATA_BITS-1:0] data_in,
  input  parity_e              parity_in,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 cnt_last;
  logic                 load_window;
  logic                 take;
  logic                 src_valid;
  logic [DATA_BITS-1:0] src_data;
  parity_e              src_par;

  assign cnt_last    = (cnt_q == CNT_LAST);
  // A new frame may be loaded when idle, or in the very last clock of the
  // final stop bit so the next start bit follows with no idle gap.
  assign load_window = (state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && (idx_q == STOP_LAST) && cnt_last);
  assign take        = load_window && src_valid;

`ifdef UART_TX_FIFO_EN
  localparam int FW = DATA_BITS + 2;

  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rd;

  uart_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_in     (valid_in),
    .wr_data_in  ({parity_in, data_in}),
    .full_out    (fifo_full),
    .pop_in      (take),
    .rd_data_out (fifo_rd),
    .empty_out   (fifo_empty)
  );

  assign src_valid = !fifo_empty;
  assign src_data  = fifo_rd[DATA_BITS-1:0];
  assign src_par   = parity_e'(fifo_rd[FW-1 -: 2]);
  assign ready_out = !rst_in && !fifo_full;
`else
  assign src_valid = valid_in;
  assign src_data  = data_in;
  assign src_par   = parity_in;
  assign ready_out = !rst_in && load_window;
`endif

  assign tx_out   = tx_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

  // Next-state logic: bit timing, data shifting and frame loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
      end
      ST_START: begin
        if (cnt_last) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_last) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = IDLE_LEVEL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            tx_d    = IDLE_LEVEL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    // Loading overrides the above; the done pulse from a finishing frame is kept.
    if (take) begin
      state_d   = ST_START;
      cnt_d     = '0;
      idx_d     = '0;
      shreg_d   = src_data;
      par_en_d  = parity_enabled(src_par);
      par_bit_d = (src_par == PAR_ODD) ? ~^src_data : ^src_data;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // FSM and datapath registers; reset returns the line high at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framed.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_framed                                               |
// | Purpose  : Self-checking bench for uart_tx_framed. Two instances: 8-bit/1  |
// |            stop and 7-bit/2 stop, CLKS_PER_BIT=4. Expected frames are      |
// |            queued on accept and checked by a line decoder per instance.    |
// |            Honours UART_TX_FIFO_EN (FIFO_DEPTH=4).                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] data0;
  logic [6:0] data1;
  parity_e    par0;
  parity_e    par1;

  always #(PER/2) clk = ~clk;

  uart_tx_framed #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_dut0 (
    .clk_in (clk), .rst_in (rst), .valid_in (valid[0]), .ready_out (ready[0]),
    .data_in (data0), .parity_in (par0), .tx_out (tx[0]), .busy_out (busy[0]),
    .done_out (done[0])
  );

  uart_tx_framed #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (7), .STOP_BITS (2), .FIFO_DEPTH (4)
  ) u_dut1 (
    .clk_in (clk), .rst_in (rst), .valid_in (valid[1]), .ready_out (ready[1]),
    .data_in (data1), .parity_in (par1), .tx_out (tx[1]), .busy_out (busy[1]),
    .done_out (done[1])
  );

  typedef struct {
    logic [8:0] d;
    logic [1:0] p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  time  starts0[$];
  int   done_cnt0 = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: line level per bit period, returns number of bit periods.
  function automatic int frame_levels(input int u, input exp_t e, output logic [15:0] lv);
    int   db;
    int   sb;
    int   n;
    logic par;
    db  = (u == 0) ? 8 : 7;
    sb  = (u == 0) ? 1 : 2;
    lv  = '1;
    n   = 0;
    par = 1'b0;
    lv[n] = 1'b0;
    n++;
    for (int k = 0; k < db; k++) begin
      lv[n] = e.d[k];
      par   = par ^ e.d[k];
      n++;
    end
    if (e.p == 2'b01) begin
      lv[n] = par;
      n++;
    end else if (e.p == 2'b10) begin
      lv[n] = ~par;
      n++;
    end
    for (int k = 0; k < sb; k++) begin
      lv[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // Line decoder: every bit period must hold its level for exactly CPB clocks,
  // busy high throughout, done only in the clock after the last stop bit.
  task automatic mon(input int u);
    exp_t        e;
    logic [15:0] lv;
    logic [3:0]  s;
    int          nb;
    bit          aborted;
    bit          busy_ok;
    int          early;
    @(negedge clk);
    forever begin
      while (rst || tx[u] !== 1'b0) @(negedge clk);
      if (u == 0) starts0.push_back($time);
      e.d = '0;
      e.p = '0;
      if (((u == 0) ? q0.size() : q1.size()) == 0) chk("spurious_start", 1, 0);
      else if (u == 0) e = q0.pop_front();
      else e = q1.pop_front();
      nb      = frame_levels(u, e, lv);
      aborted = 1'b0;
      busy_ok = 1'b1;
      early   = 0;
      s       = '0;
      for (int b = 0; b < nb && !aborted; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          s[c] = tx[u];
          if (busy[u] !== 1'b1) busy_ok = 1'b0;
          if (done[u] === 1'b1 && !(b == 0 && c == 0)) early++;
        end
        if (!aborted) chk($sformatf("u%0d_bit%0d_data%0h", u, b, e.d), 32'(s), {28'd0, {4{lv[b]}}});
      end
      if (!aborted) begin
        chk($sformatf("u%0d_busy_in_frame", u), 32'(busy_ok), 1);
        chk($sformatf("u%0d_done_early", u), early, 0);
        @(negedge clk);
        chk($sformatf("u%0d_done_at_end", u), 32'(done[u]), 1);
        if (u == 0 && done[u] === 1'b1) done_cnt0++;
      end
    end
  endtask

  // Present one word; called just after a negedge, returns just after a negedge.
  task automatic send(input int u, input logic [8:0] d, input logic [1:0] p,
                      input bit hold, input bit chk_lat);
    int   n;
    exp_t e;
    valid[u] = 1'b1;
    if (u == 0) begin
      data0 = d[7:0];
      par0  = parity_e'(p);
    end else begin
      data1 = d[6:0];
      par1  = parity_e'(p);
    end
    n = 0;
    while (ready[u] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("accept_timeout", 0, 1);
      valid[u] = 1'b0;
      return;
    end
    @(posedge clk);
    e.d = d;
    e.p = p;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
    #1;
    if (!hold) valid[u] = 1'b0;
    if (chk_lat) begin
`ifdef UART_TX_FIFO_EN
      chk("lat_fifo_stage", 32'(tx[u]), 1);
      @(posedge clk);
      #1;
`endif
      chk("lat_tx_low", 32'(tx[u]), 0);
      chk("lat_busy", 32'(busy[u]), 1);
    end
    @(negedge clk);
  endtask

  // Clocks from the frame's first start-bit clock until done_out is seen.
  task automatic wait_done(input int u, input int exp_k, input string tag);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (done[u] === 1'b1) seen = 1'b1;
    end
    chk(tag, seen ? k : 0, exp_k);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int u);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = (busy[u] === 1'b0 && tx[u] === 1'b1) ? quiet + 1 : 0;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    chk("queue_drained", (u == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    int acc;
    logic [7:0] w [6];
    rst   = 1'b1;
    valid = '0;
    data0 = '0;
    data1 = '0;
    par0  = PAR_NONE;
    par1  = PAR_NONE;
    fork
      mon(0);
      mon(1);
    join_none

    // Reset state, both instances.
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", 32'(tx[u]), 1);
      chk("rst_busy", 32'(busy[u]), 0);
      chk("rst_done", 32'(done[u]), 0);
      chk("rst_ready", 32'(ready[u]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready[0]), 1);
    @(negedge clk);

    // 8N1 0x55: 40-clock frame.
    send(0, 9'h055, 2'b00, 1'b0, 1'b1);
    wait_done(0, 40, "done_8n1");
    wait_idle(0);
    // 8E1 / 8O1 0xA3 and reserved mode 11 (no parity).
    send(0, 9'h0A3, 2'b01, 1'b0, 1'b1);
    wait_done(0, 44, "done_8e1");
    wait_idle(0);
    send(0, 9'h0A3, 2'b10, 1'b0, 1'b1);
    wait_done(0, 44, "done_8o1");
    wait_idle(0);
    send(0, 9'h03C, 2'b11, 1'b0, 1'b1);
    wait_done(0, 40, "done_par11");
    wait_idle(0);

    // 7O2 0x7F: 44-clock frame; then 7E2 and 7N2.
    send(1, 9'h07F, 2'b10, 1'b0, 1'b1);
    wait_done(1, 44, "done_7o2");
    wait_idle(1);
    send(1, 9'h015, 2'b01, 1'b0, 1'b1);
    wait_done(1, 44, "done_7e2");
    wait_idle(1);
    send(1, 9'h04A, 2'b00, 1'b0, 1'b1);
    wait_done(1, 40, "done_7n2");
    wait_idle(1);

    // Back-to-back with valid held: three gapless frames, 40 clocks apart.
    starts0.delete();
    dc0 = done_cnt0;
    send(0, 9'h012, 2'b00, 1'b1, 1'b0);
    send(0, 9'h0F0, 2'b00, 1'b1, 1'b0);
    send(0, 9'h05A, 2'b00, 1'b0, 1'b0);
    wait_idle(0);
    chk("b2b_frames", starts0.size(), 3);
    if (starts0.size() == 3) begin
      chk("b2b_gap1", int'(starts0[1] - starts0[0]), 40 * PER);
      chk("b2b_gap2", int'(starts0[2] - starts0[1]), 40 * PER);
    end
    chk("b2b_dones", done_cnt0 - dc0, 3);

    // Reset in the middle of the data bits, between clock edges.
    send(0, 9'h0C6, 2'b00, 1'b0, 1'b1);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx[0]), 1);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_ready", 32'(ready[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    send(0, 9'h081, 2'b01, 1'b0, 1'b1);
    wait_done(0, 44, "done_after_rst");
    wait_idle(0);

`ifdef UART_TX_FIFO_EN
    // Fill the 4-entry FIFO while the line is busy; order must be preserved.
    w[0] = 8'h01; w[1] = 8'h23; w[2] = 8'h45;
    w[3] = 8'h67; w[4] = 8'h89; w[5] = 8'hAB;
    send(0, 9'h011, 2'b00, 1'b0, 1'b0);
    acc = 0;
    while (acc < 6) begin
      data0    = w[acc];
      par0     = PAR_NONE;
      valid[0] = 1'b1;
      if (ready[0] !== 1'b1) break;
      @(posedge clk);
      q0.push_back('{d: {1'b0, w[acc]}, p: 2'b00});
      acc++;
      @(negedge clk);
    end
    valid[0] = 1'b0;
    chk("fifo_accepts", acc, 4);
    while (acc < 6) begin
      send(0, {1'b0, w[acc]}, 2'b00, 1'b0, 1'b0);
      acc++;
    end
    wait_idle(0);
`else
    w[0] = '0; w[1] = '0; w[2] = '0; w[3] = '0; w[4] = '0; w[5] = '0;
    acc  = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
